// File: rtl/serializador_patron.sv
// serializador_patron
// Captures a WIDTH-bit pattern from the switches on a start request and
// streams it MSB-first on x, holding each bit for DIV clock cycles so the
// downstream sequence detector sees every bit for a known number of cycles.
// The pattern can be sent once or repeated back-to-back (loop_en).
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset (0 = reset)
//   start    - request to capture pattern and begin; only looked at in IDLE
//   stop     - abort the current transmission; looked at every cycle
//   loop_en  - 1 = restart the pattern right after its last bit
//   pattern  - WIDTH-bit pattern, captured only when start is accepted
//   x        - registered serial output
//   bit_tick - one-cycle pulse in the last cycle of every bit period
//   busy     - high while a pattern is being shifted out
//   done     - one-cycle pulse after a complete pattern has been emitted
module serializador_patron #(
    parameter int WIDTH = 8,
    parameter int DIV   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [WIDTH-1:0] pattern,
    output logic             x,
    output logic             bit_tick,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DIV - 1);
    localparam logic [BW-1:0] FULL_BITS  = BW'(WIDTH);
    localparam logic [BW-1:0] ONE_BIT    = BW'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] saved_q, saved_d;
    logic [CW-1:0]    presc_q, presc_d;
    logic [BW-1:0]    bits_q, bits_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            saved_q <= '0;
            presc_q <= '0;
            bits_q  <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            saved_q <= saved_d;
            presc_q <= presc_d;
            bits_q  <= bits_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic. Every output is computed one cycle ahead so that the
    // registered copy lines up with the prescaler value it describes.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        saved_d = saved_q;
        presc_d = presc_q;
        bits_d  = bits_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                x_d    = 1'b0;
                busy_d = 1'b0;
                // stop beats start so a stuck abort switch keeps us idle
                if (start && !stop) begin
                    state_d = SHIFT;
                    saved_d = pattern;
                    shift_d = pattern;
                    x_d     = pattern[WIDTH-1];
                    busy_d  = 1'b1;
                    presc_d = '0;
                    bits_d  = FULL_BITS;
                end
            end

            SHIFT: begin
                if (stop) begin
                    state_d = IDLE;
                    x_d     = 1'b0;
                    busy_d  = 1'b0;
                    presc_d = '0;
                end else if (presc_q == LAST_COUNT) begin
                    presc_d = '0;
                    if (bits_q > ONE_BIT) begin
                        // shift_q[WIDTH-2] is the bit that becomes the MSB
                        shift_d = shift_q << 1;
                        x_d     = shift_q[WIDTH-2];
                        bits_d  = bits_q - ONE_BIT;
                    end else begin
                        done_d = 1'b1;
                        if (loop_en) begin
                            // reload without a gap so the stream is continuous
                            shift_d = saved_q;
                            x_d     = saved_q[WIDTH-1];
                            bits_d  = FULL_BITS;
                        end else begin
                            state_d = IDLE;
                            x_d     = 1'b0;
                            busy_d  = 1'b0;
                            bits_d  = '0;
                        end
                    end
                end else begin
                    presc_d = presc_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                x_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // bit_tick marks the cycle in which the prescaler will sit at its last
    // count; with DIV=1 that is every busy cycle.
    always_comb begin
        tick_d = (state_d == SHIFT) && (presc_d == LAST_COUNT);
    end

    assign x        = x_q;
    assign bit_tick = tick_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_serializador_patron.sv
// Testbench for serializador_patron. Two instances share the same inputs:
// one with WIDTH=4/DIV=4 and one with WIDTH=4/DIV=1. A reference model
// describes each pattern as a time index t inside the pattern, from which
// x, bit_tick and done follow arithmetically.
module tb_serializador_patron;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             loop_en;
    logic [WIDTH-1:0] pattern;

    logic x_slow, tick_slow, busy_slow, done_slow;
    logic x_fast, tick_fast, busy_fast, done_fast;

    int tests_run;
    int tests_failed;

    // reference model state, index 0 = DIV 4, index 1 = DIV 1
    int               mdiv   [2];
    bit               mact   [2];
    int               mt     [2];
    logic [WIDTH-1:0] msaved [2];
    bit               mdone  [2];

    logic [15:0] exp_x1011;
    logic [3:0]  exp_x1010;

    serializador_patron #(.WIDTH(WIDTH), .DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .pattern  (pattern),
        .x        (x_slow),
        .bit_tick (tick_slow),
        .busy     (busy_slow),
        .done     (done_slow)
    );

    serializador_patron #(.WIDTH(WIDTH), .DIV(1)) dut_fast (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .pattern  (pattern),
        .x        (x_fast),
        .bit_tick (tick_fast),
        .busy     (busy_fast),
        .done     (done_fast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic obs, input logic expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    function automatic logic model_x(input int i);
        if (!mact[i]) return 1'b0;
        return msaved[i][WIDTH-1 - mt[i] / mdiv[i]];
    endfunction

    function automatic logic model_tick(input int i);
        return mact[i] && ((mt[i] % mdiv[i]) == mdiv[i] - 1);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mact[i]  = 1'b0;
            mt[i]    = 0;
            mdone[i] = 1'b0;
        end
    endtask

    // one rising edge as seen by the model, using the inputs held at that edge
    task automatic modelEdge();
        for (int i = 0; i < 2; i++) begin
            mdone[i] = 1'b0;
            if (!mact[i]) begin
                if (start && !stop) begin
                    mact[i]   = 1'b1;
                    mt[i]     = 0;
                    msaved[i] = pattern;
                end
            end else if (stop) begin
                mact[i] = 1'b0;
            end else if (mt[i] == WIDTH * mdiv[i] - 1) begin
                mdone[i] = 1'b1;
                if (loop_en) mt[i] = 0;
                else mact[i] = 1'b0;
            end else begin
                mt[i]++;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".x"},        x_slow,    model_x(0));
        checkOutput({tag, ".tick"},     tick_slow, model_tick(0));
        checkOutput({tag, ".busy"},     busy_slow, mact[0]);
        checkOutput({tag, ".done"},     done_slow, mdone[0]);
        checkOutput({tag, ".fx"},       x_fast,    model_x(1));
        checkOutput({tag, ".ftick"},    tick_fast, model_tick(1));
        checkOutput({tag, ".fbusy"},    busy_fast, mact[1]);
        checkOutput({tag, ".fdone"},    done_fast, mdone[1]);
    endtask

    // drive inputs, take one clock edge, then compare 1 time unit later
    task automatic applyStimulus(input logic st, input logic sp, input logic le,
                                 input logic [WIDTH-1:0] pat, input string tag);
        start   = st;
        stop    = sp;
        loop_en = le;
        pattern = pat;
        @(posedge clk);
        if (!rst) modelReset();
        else      modelEdge();
        #1;
        checkAll(tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mdiv[0]      = 4;
        mdiv[1]      = 1;
        exp_x1011    = 16'b1111_0000_1111_1111;
        exp_x1010    = 4'b1010;
        modelReset();

        rst     = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        pattern = '0;

        // reset state, including start requested while held in reset
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1111, "reset_start");
        #2 rst = 1'b1;

        // single pattern 1011 with literal timing checks
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1011, "one_shot");
        checkOutput("one_shot.lit_x1", x_slow, exp_x1011[15]);
        for (int c = 2; c <= 16; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "one_shot");
            checkOutput("one_shot.lit_x", x_slow, exp_x1011[16 - c]);
            checkOutput("one_shot.lit_tick", tick_slow, (c % 4) == 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "one_shot_end");
        checkOutput("one_shot.lit_done", done_slow, 1'b1);
        checkOutput("one_shot.lit_busy", busy_slow, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "one_shot_idle");

        // continuous looping followed by an abort
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b1011, "loop");
        repeat (40) applyStimulus(1'b0, 1'b0, 1'b1, 4'b0110, "loop");
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, "loop_stop");
        checkOutput("loop_stop.lit_busy", busy_slow, 1'b0);
        checkOutput("loop_stop.lit_done", done_slow, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "loop_idle");

        // held start; the pattern changes while busy must be ignored
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1011, "held");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1011, "held");
        repeat (38) applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001, "held");
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "held_tail");
        repeat (16) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "held_drain");

        // asynchronous reset between edges, during the third bit
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1011, "async");
        repeat (9) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "async");
        #2 rst = 1'b0;
        #1;
        modelReset();
        checkAll("async_rst");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "async_hold");
        #2 rst = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "async_after");

        // start and stop together in IDLE
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 4'b1111, "start_stop");
        checkOutput("start_stop.lit_busy", busy_slow, 1'b0);

        // DIV=1 instance with pattern 1010
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1010, "fast");
        checkOutput("fast.lit_x1", x_fast, exp_x1010[3]);
        for (int c = 2; c <= 4; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "fast");
            checkOutput("fast.lit_x", x_fast, exp_x1010[4 - c]);
            checkOutput("fast.lit_tick", tick_fast, 1'b1);
        end
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, "fast_drain");

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 1) == 1,
                          WIDTH'($urandom),
                          "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
